spi_ram_master: RTL and testbench
=================================

Name: spi_ram_master

Overview:
- SPI initiator that drives the MOSI/SS_n side of the SPI-slave + RAM wrapper and collects MISO read data.
- A local command port accepts one RAM operation at a time: write-address, write-data, read-address or read-data.
- The block serialises each operation into a 10-bit frame. For read-data it then deserialises the 8-bit reply.
- It sits between the test/host logic and the SPI wrapper, sharing the wrapper's single clock.

Parameters:
- TURNAROUND, 2, idle clk cycles between the last MOSI frame bit and the first MISO sample of a read-data op; legal range 1..15.
- ADDR_W, 8, payload width; fixed at 8 (frame = 2 op bits + 8 payload bits).

Ports:
- clk  input  1  system clock, also the SPI bit clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command (IDLE only).
- cmd_op  input  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- cmd_payload  input  8  address or write data; ignored for 11.
- done  output  1  one-cycle pulse at end of every operation.
- rsp_valid  output  1  one-cycle pulse, read-data reply available.
- rsp_data  output  8  read-data reply; holds until next rd-data completes.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: SS_n=1, MOSI=0, cmd_ready=1 after reset release, done=0, rsp_valid=0, rsp_data=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately: SS_n=1 on the next edge and no done or rsp_valid pulse.
- Handshake: a command is accepted on the edge where cmd_valid && cmd_ready. In that edge the block latches frame = {cmd_op, cmd_payload}.
- cmd_ready=0 from the cycle after acceptance until FSM returns to IDLE. A cmd_valid held high is accepted in the first IDLE cycle.
- FSM states: IDLE, CTRL, SHIFT, TURN, RECV, END.
- Timing is relative to accept edge T:
  - CTRL (cycle T+1): SS_n=0, MOSI=frame[9] (control bit).
  - SHIFT (cycles T+2..T+11): MOSI=frame[9] down to frame[0], MSB first, one bit per cycle, 4-bit counter 9→0.
  - After SHIFT, op≠11 goes to END at T+12. Op=11 goes to TURN.
  - TURN: TURNAROUND cycles with SS_n=0 and MOSI=0.
  - RECV: 8 cycles with SS_n=0 and MOSI=0. The master samples MISO at the end of each cycle into a shift register, MSB first (sr <= {sr[6:0], MISO}).
  - END (1 cycle): SS_n=1, MOSI=0, done=1. For op=11 also rsp_valid=1 and rsp_data=assembled byte, visible in the same cycle. Then IDLE.
- Latency:
  - write / rd-addr: done at T+12.
  - rd-data: done and rsp_valid at T+12+TURNAROUND+8, i.e. T+22 with the default.
- Back-to-back operations: SS_n is high for a minimum of 2 cycles (END + IDLE accept cycle) between frames.
- MISO is ignored outside RECV.
- cmd_op and cmd_payload changes after acceptance have no effect.

Optional Feature:
- Macro: SPI_MASTER_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in any state other than IDLE or END forces END-without-pulse on the next edge: SS_n=1, done=0, rsp_valid=0, rsp_data unchanged. IDLE follows one cycle later.
  - abort in IDLE or END is ignored.
  - If reset and abort are asserted together, reset takes priority.
- Not defined: no abort port; frames always run to completion.

Test Plan:
- Reset, then wr-addr op=00, payload=0xA5 → SS_n low at T+1; MOSI sequence 0, 0,0,1,0,1,0,0,1,0,1; done at T+12; rsp_valid stays 0.
- wr-data op=01, payload=0x3C, with cmd_valid held for a second op=01 payload=0x00 → second accept at T+13; SS_n high at T+12 and T+13; second frame bits correct.
- rd-data op=11 with slave model returning 0xC3, default TURNAROUND → MISO sampled over cycles T+15..T+22; rsp_valid=1 and rsp_data=0xC3 at T+22; done same cycle.
- rd-data with TURNAROUND=5, reply 0x81 → rsp_valid at T+25 with 0x81; rsp_data holds 0x81 through a following wr-addr op.
- rst asserted at T+6 of a rd-data frame → SS_n=1 and cmd_ready=1 after reset release; no done or rsp_valid pulse; rsp_data=0.
- With SPI_MASTER_ABORT_EN: abort=1 at T+16 of rd-data → SS_n=1 at T+17; no rsp_valid; IDLE and cmd_ready=1 at T+18.

Source files
------------

// File: rtl/spi_ram_master.sv
// SPI initiator for the SPI-slave + RAM wrapper: serialises 10-bit command frames and collects 8-bit read replies.
// Optional abort input enabled by defining SPI_MASTER_ABORT_EN.
module spi_ram_master #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SPI_MASTER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_payload,
  output logic              done,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CTRL  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_RECV  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  localparam logic [3:0] SHIFT_LOAD = 4'(ADDR_W + 1);
  localparam logic [3:0] TURN_LOAD  = 4'(TURNAROUND - 1);
  localparam logic [3:0] RECV_LOAD  = 4'd7;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] frame_q, frame_d;
  logic [6:0]        sr_q, sr_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              aborted_q, aborted_d;
  logic              abort_w;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    sr_d       = sr_q;
    rsp_data_d = rsp_data_q;
    aborted_d  = aborted_q;

    case (state_q)
      S_IDLE: begin
        aborted_d = 1'b0;
        if (cmd_valid) begin
          frame_d = {cmd_op, cmd_payload};
          state_d = S_CTRL;
        end
      end
      S_CTRL: begin
        state_d = S_SHIFT;
        cnt_d   = SHIFT_LOAD;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (frame_q[ADDR_W+1:ADDR_W] == 2'b11) begin
            state_d = S_TURN;
            cnt_d   = TURN_LOAD;
          end else begin
            state_d = S_END;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_RECV;
          cnt_d   = RECV_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECV: begin
        sr_d = {sr_q[5:0], MISO};
        if (cnt_q == '0) begin
          // Final sample goes straight into the reply so it is visible in END.
          rsp_data_d = {sr_q, MISO};
          state_d    = S_END;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_END: begin
        state_d   = S_IDLE;
        aborted_d = 1'b0;
        cnt_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort lands in END with the pulse suppressed; the reply register is left alone.
    if (abort_w && (state_q != S_IDLE) && (state_q != S_END)) begin
      state_d    = S_END;
      aborted_d  = 1'b1;
      cnt_d      = '0;
      sr_d       = sr_q;
      rsp_data_d = rsp_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      sr_q       <= '0;
      rsp_data_q <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      sr_q       <= sr_d;
      rsp_data_q <= rsp_data_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    SS_n      = (state_q == S_IDLE) || (state_q == S_END);
    MOSI      = 1'b0;
    if (state_q == S_CTRL) begin
      MOSI = frame_q[ADDR_W+1];
    end else if (state_q == S_SHIFT) begin
      MOSI = frame_q[cnt_q];
    end
    done      = (state_q == S_END) && !aborted_q;
    rsp_valid = done && (frame_q[ADDR_W+1:ADDR_W] == 2'b11);
    rsp_data  = rsp_data_q;
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: two instances (TURNAROUND 2 and 5) against a cycle-indexed frame model.
module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid0 = 1'b0;
  logic       cmd_valid1 = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_payload = '0;
  logic       miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic       rdy0, done0, rv0, ss0, mosi0;
  logic       rdy1, done1, rv1, ss1, mosi1;
  logic [7:0] rd0, rd1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rsp [2];

  always #5 clk = ~clk;

  spi_ram_master #(.TURNAROUND(2), .ADDR_W(8)) dut0 (
    .clk(clk), .rst(rst),
`ifdef SPI_MASTER_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid0), .cmd_ready(rdy0), .cmd_op(cmd_op), .cmd_payload(cmd_payload),
    .done(done0), .rsp_valid(rv0), .rsp_data(rd0), .SS_n(ss0), .MOSI(mosi0), .MISO(miso)
  );

  spi_ram_master #(.TURNAROUND(5), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst),
`ifdef SPI_MASTER_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid1), .cmd_ready(rdy1), .cmd_op(cmd_op), .cmd_payload(cmd_payload),
    .done(done1), .rsp_valid(rv1), .rsp_data(rd1), .SS_n(ss1), .MOSI(mosi1), .MISO(miso)
  );

  // Observation vector: {SS_n, MOSI, done, rsp_valid, cmd_ready, rsp_data}
  function automatic logic [12:0] get_obs(input int sel);
    if (sel == 1) return {ss1, mosi1, done1, rv1, rdy1, rd1};
    return {ss0, mosi0, done0, rv0, rdy0, rd0};
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 1) cmd_valid1 = v;
    else cmd_valid0 = v;
  endtask

  // Runs one command from its accept cycle (k=0) to END (k=L), comparing every cycle.
  // rst_at / abort_at > 0 inject that event at cycle T+k and end the frame there.
  task automatic run_frame(input int sel, input logic [1:0] op, input logic [7:0] pl,
                           input logic [7:0] reply, input bit keep, input int rst_at,
                           input int abort_at, input string name);
    int ta, len, bit_idx;
    logic [9:0]  frame;
    logic [12:0] got, exp;
    ta    = (sel == 1) ? 5 : 2;
    len   = (op == 2'b11) ? 12 + ta + 8 : 12;
    frame = {op, pl};

    @(negedge clk);
    cmd_op = op;
    cmd_payload = pl;
    set_valid(sel, 1'b1);
    miso = 1'($urandom);
    got = get_obs(sel);
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_rsp[sel]};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d accept cycle: got ss/mosi/done/rv/rdy=%b data=%h, expected %b data=%h",
               name, sel, got[12:8], got[7:0], exp[12:8], exp[7:0]);
    end

    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!keep) set_valid(sel, 1'b0);
        cmd_op = 2'($urandom);
        cmd_payload = 8'($urandom);
      end
      if (k == len) begin
        if (op == 2'b11) exp_rsp[sel] = reply;
        exp = {1'b1, 1'b0, 1'b1, (op == 2'b11), 1'b0, exp_rsp[sel]};
      end else begin
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_rsp[sel]};
        if (k == 1) exp[11] = frame[9];
        else if (k <= 11) exp[11] = frame[11-k];
      end
      got = get_obs(sel);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s dut%0d cycle T+%0d: got ss/mosi/done/rv/rdy=%b data=%h, expected %b data=%h",
                 name, sel, k, got[12:8], got[7:0], exp[12:8], exp[7:0]);
      end

      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        exp_rsp[0] = '0;
        exp_rsp[1] = '0;
        got = get_obs(sel);
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s dut%0d in reset: got %b data=%h, expected %b data=%h",
                   name, sel, got[12:8], got[7:0], exp[12:8], exp[7:0]);
        end
        rst = 1'b0;
        @(negedge clk);
        got = get_obs(sel);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s dut%0d after reset: got %b data=%h, expected %b data=%h",
                   name, sel, got[12:8], got[7:0], exp[12:8], exp[7:0]);
        end
        return;
      end

`ifdef SPI_MASTER_ABORT_EN
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        got = get_obs(sel);
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_rsp[sel]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s dut%0d T+%0d abort END: got %b data=%h, expected %b data=%h",
                   name, sel, k + 1, got[12:8], got[7:0], exp[12:8], exp[7:0]);
        end
        @(negedge clk);
        got = get_obs(sel);
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_rsp[sel]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s dut%0d T+%0d abort IDLE: got %b data=%h, expected %b data=%h",
                   name, sel, k + 2, got[12:8], got[7:0], exp[12:8], exp[7:0]);
        end
        return;
      end
`endif

      // Reply bits only during the receive window; random noise elsewhere must be ignored.
      bit_idx = k - (12 + ta);
      if (op == 2'b11 && bit_idx >= 0 && bit_idx < 8) miso = reply[7-bit_idx];
      else miso = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [12:0] got, exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_rsp[0] = '0;
    exp_rsp[1] = '0;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    for (int s = 0; s < 2; s++) begin
      got = get_obs(s);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %b data=%h, expected %b data=%h",
                 s, got[12:8], got[7:0], exp[12:8], exp[7:0]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      got = get_obs(s);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %b data=%h, expected %b data=%h",
                 s, got[12:8], got[7:0], exp[12:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_wr_addr();
    run_frame(0, 2'b00, 8'hA5, 8'h00, 1'b0, 0, 0, "wr_addr_a5");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 2'b01, 8'h3C, 8'h00, 1'b1, 0, 0, "b2b_first");
    run_frame(0, 2'b01, 8'h00, 8'h00, 1'b0, 0, 0, "b2b_second");
  endtask

  task automatic test_rd_data();
    run_frame(0, 2'b11, 8'h00, 8'hC3, 1'b0, 0, 0, "rd_data_c3");
  endtask

  task automatic test_rd_data_ta5();
    run_frame(1, 2'b11, 8'h5A, 8'h81, 1'b0, 0, 0, "rd_data_ta5_81");
    run_frame(1, 2'b00, 8'h17, 8'h00, 1'b0, 0, 0, "hold_after_rd");
  endtask

  task automatic test_reset_mid_frame();
    run_frame(0, 2'b11, 8'h00, 8'hFF, 1'b0, 6, 0, "reset_mid_frame");
  endtask

`ifdef SPI_MASTER_ABORT_EN
  task automatic test_abort();
    run_frame(0, 2'b11, 8'h00, 8'h66, 1'b0, 0, 0, "pre_abort_rd");
    run_frame(0, 2'b11, 8'h00, 8'h99, 1'b0, 0, 16, "abort_rd_data");
    run_frame(0, 2'b10, 8'h42, 8'h00, 1'b0, 0, 0, "post_abort_rd_addr");
  endtask
`endif

  task automatic test_random();
    int n;
    n = 12;
    for (int i = 0; i < n; i++) begin
      run_frame(0, 2'($urandom), 8'($urandom), 8'($urandom),
                (i < n - 1) ? 1'($urandom) : 1'b0, 0, 0, "random_ta2");
    end
    for (int i = 0; i < 4; i++) begin
      run_frame(1, 2'($urandom), 8'($urandom), 8'($urandom),
                (i < 3) ? 1'($urandom) : 1'b0, 0, 0, "random_ta5");
    end
  endtask

  initial begin
    test_reset();
    test_wr_addr();
    test_back_to_back();
    test_rd_data();
    test_rd_data_ta5();
    test_reset_mid_frame();
`ifdef SPI_MASTER_ABORT_EN
    test_abort();
`endif
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
